mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
- Multi-cycle successor to the single-cycle Control decoder.
- Moore-style FSM that sequences a MIPS datapath (shared memory, IR, A/B, ALUOut, MDR) over 3–5 cycles per instruction.
- Adds a memory ready handshake with timeout, `addi` support and illegal-opcode flagging.
- Sits between the instruction register (opcode/funct inputs) and the datapath mux and enable controls.

Parameters:
- `ALUC_W`, 3, ALUControl width. Encodings zero-extended: AND=0, OR=1, ADD=2, SUB=6, SLT=7.
- `TIMEOUT_W`, 4, width of the memory-wait counter.
- `MEM_TIMEOUT`, 12, maximum cycles to wait for `mem_ready`. Must be ≥1 and < 2^TIMEOUT_W.
- `EN_ADDI`, 1, when 1, opcode 001000 (`addi`) is legal; when 0 it is illegal.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `opcode`  in  6  IR[31:26], valid from DECODE onward
- `funct`  in  6  IR[5:0]
- `mem_ready`  in  1  memory completes the current request this cycle
- `PCWrite`, `PCWriteCond`, `PCWriteCondNe`  out  1 each  unconditional PC write / PC write if zero (beq) / PC write if not zero (bne)
- `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `MemToReg`, `RegDst`, `RegWrite`, `ALUSrcA`  out  1 each  classic multicycle controls
- `ALUSrcB`  out  2  00=B, 01=4, 10=signext imm, 11=signext imm<<2
- `PCSrc`  out  2  00=ALU, 01=ALUOut, 10=jump target
- `ALUControl`  out  ALUC_W  ALU operation
- `illegal`  out  1  one-cycle pulse on an undecodable instruction
- `mem_err`  out  1  one-cycle pulse on a memory timeout
- `state`  out  4  current state encoding, for debug

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Codes 12–15 are unused and go to FETCH.
- Reset (async assert, sync release): state=FETCH, wait counter=0. Every output takes its FETCH value with `mem_ready`=0, i.e. only `MemRead`=1, `ALUSrcB`=01 and `ALUControl`=ADD are high/set.
- Default value of every output is 0, apart from the per-state values below.
- FETCH:
  - Outputs: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUControl`=ADD, `PCSrc`=00.
  - `IRWrite` and `PCWrite` equal `mem_ready` (Mealy), so PC+4 and the IR load happen exactly once.
  - Go to DECODE when `mem_ready`=1; otherwise stay.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUControl`=ADD (branch target into ALUOut). Next state by opcode:
  - 000000 (R-type) -> EXEC
  - 100011 (`lw`) and 101011 (`sw`) -> MEMADR
  - 000100 (`beq`) and 000101 (`bne`) -> BRANCH
  - 000010 (`j`) -> JUMP
  - 001000 (`addi`) -> ADDIEX if `EN_ADDI`=1
  - Anything else -> FETCH with `illegal`=1 for that cycle.
- MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, ADD. Next is MEMRD for `lw`, MEMWR for `sw`.
- MEMRD: `MemRead`=1, `IorD`=1. Wait for `mem_ready`, then go to MEMWB.
- MEMWB: `RegWrite`=1, `MemToReg`=1, `RegDst`=0. Next is FETCH.
- MEMWR: `MemWrite`=1, `IorD`=1. Wait for `mem_ready`, then go to FETCH.
- EXEC: `ALUSrcA`=1, `ALUSrcB`=00. `ALUControl` from `funct`:
  - 100000=ADD, 100010=SUB, 100100=AND, 100101=OR, 101010=SLT.
  - Any other funct -> FETCH with `illegal`=1; ALUWB is not entered and there is no register write.
- ALUWB: `RegWrite`=1, `RegDst`=1, `MemToReg`=0. Next is FETCH.
- BRANCH: `ALUSrcA`=1, `ALUSrcB`=00, SUB, `PCSrc`=01. `PCWriteCond`=1 for `beq`, `PCWriteCondNe`=1 for `bne`, never both. Next is FETCH.
- JUMP: `PCWrite`=1, `PCSrc`=10. Next is FETCH.
- ADDIEX: `ALUSrcA`=1, `ALUSrcB`=10, ADD. Next is ADDIWB.
- ADDIWB: `RegWrite`=1, `RegDst`=0, `MemToReg`=0. Next is FETCH.
- Memory wait timer (FETCH, MEMRD, MEMWR):
  - Counter is cleared on entry to a wait state and increments each cycle `mem_ready`=0.
  - On the cycle the counter equals `MEM_TIMEOUT`-1 with `mem_ready`=0: pulse `mem_err`, go to FETCH. No `IRWrite`, `PCWrite` or `RegWrite` is issued.
  - `mem_ready`=1 on that same cycle wins: normal completion, no `mem_err`.
- Cycle counts with zero-wait memory: `lw` 5, `sw` 4, R-type/`addi` 4, branch/jump 3.
- Reset asserted mid-instruction: immediate return to FETCH and all outputs go to their reset values. No partial write may complete after `rst_n` falls.

Test Plan:
- R-type add (opcode 000000, funct 100000), `mem_ready` tied 1 -> states 0,1,6,7,0. `ALUControl`=010 in EXEC; `RegWrite`=1 and `RegDst`=1 only in ALUWB. Repeat for funct 100010/100100/100101/101010 -> `ALUControl` 110/000/001/111.
- `lw` (100011) with `mem_ready` low 3 cycles in MEMRD -> MEMRD held 4 cycles with `MemRead`=1, `IorD`=1; then MEMWB with `RegWrite`=1, `MemToReg`=1; 8 cycles total. `sw` (101011) -> single `MemWrite` phase, no `RegWrite` in any cycle.
- `beq` (000100) -> `PCWriteCond`=1, `PCWriteCondNe`=0, `PCSrc`=01, SUB in BRANCH. `bne` (000101) -> the inverse. `j` (000010) -> `PCWrite`=1, `PCSrc`=10, 3 cycles total.
- Illegal opcode 111111 and R-type funct 000111 -> `illegal` pulses exactly 1 cycle, next state FETCH, no `RegWrite`, `MemWrite` or `PCWrite`. `addi` with `EN_ADDI`=0 -> `illegal`=1; with `EN_ADDI`=1 -> states 0,1,10,11,0.
- `mem_ready` held 0 in FETCH with `MEM_TIMEOUT`=12 -> `mem_err` pulses in the 12th cycle and `IRWrite` is never asserted. `mem_ready`=1 exactly in the 12th cycle -> DECODE entered, no `mem_err`.
- `rst_n` pulled low asynchronously during MEMWR (between clock edges) -> `MemWrite` drops immediately and `state`=0. After release the FSM restarts a clean fetch.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control: Moore-style multicycle MIPS control FSM with memory-ready timeout and illegal-instruction flagging.
module mips_multicycle_control #(
    parameter int ALUC_W      = 3,
    parameter int TIMEOUT_W   = 4,
    parameter int MEM_TIMEOUT = 12,
    parameter bit EN_ADDI     = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [5:0]        opcode,
    input  logic [5:0]        funct,
    input  logic              mem_ready,
    output logic              PCWrite,
    output logic              PCWriteCond,
    output logic              PCWriteCondNe,
    output logic              IorD,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              IRWrite,
    output logic              MemToReg,
    output logic              RegDst,
    output logic              RegWrite,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [1:0]        PCSrc,
    output logic [ALUC_W-1:0] ALUControl,
    output logic              illegal,
    output logic              mem_err,
    output logic [3:0]        state
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
        EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, ADDIEX = 4'd10, ADDIWB = 4'd11
    } state_t;
    localparam logic [ALUC_W-1:0] A_AND = ALUC_W'(0);
    localparam logic [ALUC_W-1:0] A_OR  = ALUC_W'(1);
    localparam logic [ALUC_W-1:0] A_ADD = ALUC_W'(2);
    localparam logic [ALUC_W-1:0] A_SUB = ALUC_W'(6);
    localparam logic [ALUC_W-1:0] A_SLT = ALUC_W'(7);
    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 wait_st, tmo;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end
    assign state = state_q;
    always_comb begin
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        PCWriteCondNe = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        MemToReg      = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        PCSrc         = 2'b00;
        ALUControl    = '0;
        illegal       = 1'b0;
        state_d       = FETCH;
        wait_st       = state_q inside {FETCH, MEMRD, MEMWR};
        tmo           = wait_st && !mem_ready && cnt_q == TIMEOUT_W'(MEM_TIMEOUT - 1);
        mem_err       = tmo;
        // counter restarts on every entry to a wait state, including a timeout back into FETCH
        cnt_d         = (wait_st && !mem_ready && !tmo) ? cnt_q + 1'b1 : '0;
        case (state_q)
            FETCH: begin
                MemRead    = 1'b1;
                ALUSrcB    = 2'b01;
                ALUControl = A_ADD;
                IRWrite    = mem_ready;
                PCWrite    = mem_ready;
                state_d    = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcB    = 2'b11;
                ALUControl = A_ADD;
                case (opcode)
                    6'b000000:            state_d = EXEC;
                    6'b100011, 6'b101011: state_d = MEMADR;
                    6'b000100, 6'b000101: state_d = BRANCH;
                    6'b000010:            state_d = JUMP;
                    6'b001000: begin
                        state_d = EN_ADDI ? ADDIEX : FETCH;
                        illegal = !EN_ADDI;
                    end
                    default:              illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = A_ADD;
                state_d    = (opcode == 6'b101011) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                state_d = mem_ready ? MEMWB : (tmo ? FETCH : MEMRD);
            end
            MEMWB: begin
                RegWrite = 1'b1;
                MemToReg = 1'b1;
            end
            MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                state_d  = (mem_ready || tmo) ? FETCH : MEMWR;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                state_d = ALUWB;
                case (funct)
                    6'b100000: ALUControl = A_ADD;
                    6'b100010: ALUControl = A_SUB;
                    6'b100100: ALUControl = A_AND;
                    6'b100101: ALUControl = A_OR;
                    6'b101010: ALUControl = A_SLT;
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            BRANCH: begin
                ALUSrcA       = 1'b1;
                ALUControl    = A_SUB;
                PCSrc         = 2'b01;
                PCWriteCond   = opcode == 6'b000100;
                PCWriteCondNe = opcode == 6'b000101;
            end
            JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = 2'b10;
            end
            ADDIEX: begin
                ALUSrcA    = 1'b1;
                ALUSrcB    = 2'b10;
                ALUControl = A_ADD;
                state_d    = ADDIWB;
            end
            ADDIWB:  RegWrite = 1'b1;
            default: state_d = FETCH;
        endcase
    end
endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control: directed per-cycle checks of state and every control output.
module tb_mips_multicycle_control;
    typedef struct packed {
        logic pcw, pcc, pcn, iord, mr, mw, irw, m2r, rd, rw, asa;
        logic [1:0] asb, pcs;
        logic [2:0] aluc;
        logic ill, merr;
    } ctl_t;
    localparam ctl_t F0  = '{mr: 1'b1, asb: 2'd1, aluc: 3'd2, default: 0};
    localparam ctl_t F1  = '{pcw: 1'b1, mr: 1'b1, irw: 1'b1, asb: 2'd1, aluc: 3'd2, default: 0};
    localparam ctl_t TO  = '{mr: 1'b1, asb: 2'd1, aluc: 3'd2, merr: 1'b1, default: 0};
    localparam ctl_t DEC = '{asb: 2'd3, aluc: 3'd2, default: 0};
    localparam ctl_t DIL = '{asb: 2'd3, aluc: 3'd2, ill: 1'b1, default: 0};
    localparam ctl_t MAD = '{asa: 1'b1, asb: 2'd2, aluc: 3'd2, default: 0};
    localparam ctl_t MRD = '{mr: 1'b1, iord: 1'b1, default: 0};
    localparam ctl_t MWB = '{rw: 1'b1, m2r: 1'b1, default: 0};
    localparam ctl_t MWR = '{mw: 1'b1, iord: 1'b1, default: 0};
    localparam ctl_t AWB = '{rw: 1'b1, rd: 1'b1, default: 0};
    localparam ctl_t BEQ = '{asa: 1'b1, aluc: 3'd6, pcs: 2'd1, pcc: 1'b1, default: 0};
    localparam ctl_t BNE = '{asa: 1'b1, aluc: 3'd6, pcs: 2'd1, pcn: 1'b1, default: 0};
    localparam ctl_t JMP = '{pcw: 1'b1, pcs: 2'd2, default: 0};
    localparam ctl_t XIL = '{asa: 1'b1, ill: 1'b1, default: 0};
    localparam ctl_t IWB = '{rw: 1'b1, default: 0};
    logic clk = 1'b0, rst_n, mem_ready;
    logic [5:0] opcode, funct;
    logic PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic [2:0] ALUControl;
    logic illegal, mem_err;
    logic [3:0] state;
    logic PCWrite_0, PCWriteCond_0, PCWriteCondNe_0, IorD_0, MemRead_0, MemWrite_0, IRWrite_0, MemToReg_0, RegDst_0, RegWrite_0, ALUSrcA_0;
    logic [1:0] ALUSrcB_0, PCSrc_0;
    logic [2:0] ALUControl_0;
    logic illegal_0, mem_err_0;
    logic [3:0] state_0;
    ctl_t ctl, ctl0;
    int n_vec = 0, n_err = 0;
    always #5 clk = ~clk;
    mips_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCWriteCondNe(PCWriteCondNe), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemToReg(MemToReg), .RegDst(RegDst),
        .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .ALUControl(ALUControl),
        .illegal(illegal), .mem_err(mem_err), .state(state)
    );
    mips_multicycle_control #(.EN_ADDI(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
        .PCWrite(PCWrite_0), .PCWriteCond(PCWriteCond_0), .PCWriteCondNe(PCWriteCondNe_0), .IorD(IorD_0),
        .MemRead(MemRead_0), .MemWrite(MemWrite_0), .IRWrite(IRWrite_0), .MemToReg(MemToReg_0), .RegDst(RegDst_0),
        .RegWrite(RegWrite_0), .ALUSrcA(ALUSrcA_0), .ALUSrcB(ALUSrcB_0), .PCSrc(PCSrc_0), .ALUControl(ALUControl_0),
        .illegal(illegal_0), .mem_err(mem_err_0), .state(state_0)
    );
    assign ctl = {PCWrite, PCWriteCond, PCWriteCondNe, IorD, MemRead, MemWrite, IRWrite, MemToReg, RegDst,
                  RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUControl, illegal, mem_err};
    assign ctl0 = {PCWrite_0, PCWriteCond_0, PCWriteCondNe_0, IorD_0, MemRead_0, MemWrite_0, IRWrite_0, MemToReg_0,
                   RegDst_0, RegWrite_0, ALUSrcA_0, ALUSrcB_0, PCSrc_0, ALUControl_0, illegal_0, mem_err_0};
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic cyc(input string tag, input logic rdy, input logic [3:0] st, input ctl_t c);
        mem_ready = rdy;
        #1;
        chk({tag, "/state"}, 32'(state), 32'(st));
        chk({tag, "/ctl"}, 32'(ctl), 32'(c));
        @(negedge clk);
    endtask
    initial begin
        logic [5:0] fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        logic [2:0] ac [5] = '{3'd2, 3'd6, 3'd0, 3'd1, 3'd7};
        rst_n = 1'b0;
        mem_ready = 1'b0;
        opcode = 6'b0;
        funct = 6'b0;
        #2;
        chk("reset/state", 32'(state), 32'd0);
        chk("reset/ctl", 32'(ctl), 32'(F0));
        chk("reset0/ctl", 32'(ctl0), 32'(F0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            funct = fn[i];
            cyc("r/fetch", 1'b1, 4'd0, F1);
            cyc("r/decode", 1'b1, 4'd1, DEC);
            cyc("r/exec", 1'b1, 4'd6, '{asa: 1'b1, aluc: ac[i], default: 0});
            cyc("r/aluwb", 1'b1, 4'd7, AWB);
        end
        opcode = 6'b100011;
        cyc("lw/fetch", 1'b1, 4'd0, F1);
        cyc("lw/decode", 1'b1, 4'd1, DEC);
        cyc("lw/memadr", 1'b1, 4'd2, MAD);
        for (int i = 0; i < 3; i++) cyc("lw/memrd_wait", 1'b0, 4'd3, MRD);
        cyc("lw/memrd", 1'b1, 4'd3, MRD);
        cyc("lw/memwb", 1'b1, 4'd4, MWB);
        opcode = 6'b101011;
        cyc("sw/fetch", 1'b1, 4'd0, F1);
        cyc("sw/decode", 1'b1, 4'd1, DEC);
        cyc("sw/memadr", 1'b1, 4'd2, MAD);
        cyc("sw/memwr", 1'b1, 4'd5, MWR);
        opcode = 6'b000100;
        cyc("beq/fetch", 1'b1, 4'd0, F1);
        cyc("beq/decode", 1'b1, 4'd1, DEC);
        cyc("beq/branch", 1'b1, 4'd8, BEQ);
        opcode = 6'b000101;
        cyc("bne/fetch", 1'b1, 4'd0, F1);
        cyc("bne/decode", 1'b1, 4'd1, DEC);
        cyc("bne/branch", 1'b1, 4'd8, BNE);
        opcode = 6'b000010;
        cyc("j/fetch", 1'b1, 4'd0, F1);
        cyc("j/decode", 1'b1, 4'd1, DEC);
        cyc("j/jump", 1'b1, 4'd9, JMP);
        opcode = 6'b111111;
        cyc("ilop/fetch", 1'b1, 4'd0, F1);
        cyc("ilop/decode", 1'b1, 4'd1, DIL);
        opcode = 6'b000000;
        funct = 6'b000111;
        cyc("ilfn/fetch", 1'b1, 4'd0, F1);
        cyc("ilfn/decode", 1'b1, 4'd1, DEC);
        cyc("ilfn/exec", 1'b1, 4'd6, XIL);
        opcode = 6'b001000;
        cyc("addi/fetch", 1'b1, 4'd0, F1);
        mem_ready = 1'b1;
        #1;
        chk("addi/decode/state", 32'(state), 32'd1);
        chk("addi/decode/ctl", 32'(ctl), 32'(DEC));
        chk("addi0/decode/state", 32'(state_0), 32'd1);
        chk("addi0/decode/ctl", 32'(ctl0), 32'(DIL));
        @(negedge clk);
        #1;
        chk("addi/ex/state", 32'(state), 32'd10);
        chk("addi/ex/ctl", 32'(ctl), 32'(MAD));
        chk("addi0/after/state", 32'(state_0), 32'd0);
        @(negedge clk);
        cyc("addi/wb", 1'b1, 4'd11, IWB);
        opcode = 6'b000010;
        for (int i = 0; i < 11; i++) cyc("to/wait", 1'b0, 4'd0, F0);
        cyc("to/expire", 1'b0, 4'd0, TO);
        for (int i = 0; i < 11; i++) cyc("to2/wait", 1'b0, 4'd0, F0);
        cyc("to2/ready_last", 1'b1, 4'd0, F1);
        cyc("to2/decode", 1'b1, 4'd1, DEC);
        cyc("to2/jump", 1'b1, 4'd9, JMP);
        opcode = 6'b101011;
        cyc("rst/fetch", 1'b1, 4'd0, F1);
        cyc("rst/decode", 1'b1, 4'd1, DEC);
        cyc("rst/memadr", 1'b1, 4'd2, MAD);
        mem_ready = 1'b0;
        #1;
        chk("rst/memwr/state", 32'(state), 32'd5);
        chk("rst/memwr/MemWrite", 32'(MemWrite), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst/async/state", 32'(state), 32'd0);
        chk("rst/async/MemWrite", 32'(MemWrite), 32'd0);
        chk("rst/async/ctl", 32'(ctl), 32'(F0));
        @(negedge clk);
        rst_n = 1'b1;
        opcode = 6'b000010;
        cyc("rst/re_fetch", 1'b1, 4'd0, F1);
        cyc("rst/re_decode", 1'b1, 4'd1, DEC);
        cyc("rst/re_jump", 1'b1, 4'd9, JMP);
        cyc("rst/re_done", 1'b0, 4'd0, F0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
